temporizador_antirrebote: RTL
=============================

# temporizador_antirrebote

Programmable time-out generator that feeds the button debouncer. When the debouncer raises its count-request line `actCuenta`, this block measures a fixed interval (300 ms at board clock by default) and returns a single-cycle `t300ms` pulse. The debouncer uses that pulse to re-sample the button. The block sits directly upstream of the debouncer's `t300ms` input and is clocked from the same `Clk`.

## Interface
Parameters:
- `TICK_CYCLES`, default 100000: `Clk` cycles per base tick (1 ms at 100 MHz); must be ≥ 2.
- `N_TICKS`, default 300: base ticks per interval; must be ≥ 1.
- Counter widths: `$clog2(TICK_CYCLES)` and `$clog2(N_TICKS+1)`.

Ports:
- `Clk`, in, 1: single system clock; all logic on the rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `actCuenta`, in, 1: count request from the debouncer; a level, held high for the whole wait.
- `t300ms`, out, 1: interval-expired pulse, exactly one `Clk` cycle wide, registered.
- `contando`, out, 1: high while an interval is being timed, registered.
- `tick`, out, 1: one-cycle base-tick strobe, valid only while `contando` is high; for debug/bench.

## Operation
- FSM states:
  - `IDLE`: counters held at 0.
  - `COUNT`: timing the interval.
  - `DONE`: interval expired; waiting for the request to drop.
- `IDLE` → `COUNT` on an edge that samples `actCuenta`=1. At that edge the prescaler `pre`=0, `ticks`=0, and `contando` goes 1.
- Each edge in `COUNT` with `actCuenta`=1:
  - If `pre` < `TICK_CYCLES-1`: `pre`++.
  - Otherwise: `pre`←0, `tick`←1, `ticks`++.
- Expiry: on an edge in `COUNT` where `pre`=`TICK_CYCLES-1`, `ticks`=`N_TICKS-1` and `actCuenta`=1:
  - `t300ms`←1, state → `DONE`, `contando`←0.
- `DONE`:
  - `t300ms` returns to 0 on the next edge.
  - The block stays in `DONE`, with no re-fire, while `actCuenta`=1.
  - An edge sampling `actCuenta`=0 → `IDLE`.
- Abort: an edge in `COUNT` that samples `actCuenta`=0 → `IDLE`, counters cleared, no pulse.
- Simultaneous expiry and `actCuenta`=0 on the same edge: abort wins, no `t300ms`.
- `IDLE` with `actCuenta`=0: no activity, all outputs 0.
- `Reset` asserted at any time, including mid-count or during the `t300ms` cycle:
  - State → `IDLE`, `pre`=`ticks`=0.
  - `t300ms`=`contando`=`tick`=0 immediately.
- After `Reset` deasserts, a fresh full interval is timed; nothing resumes.
- Counters never wrap: `ticks` cannot exceed `N_TICKS-1` in `COUNT`.

## Timing
- Reset values: `t300ms`=0, `contando`=0, `tick`=0, state `IDLE`.
- Latency: let edge E0 sample `actCuenta`=1 in `IDLE`.
  - `t300ms` is high after edge E0 + `TICK_CYCLES`·`N_TICKS`.
  - It is low again after the following edge.
- `tick` is high after edges E0 + k·`TICK_CYCLES`, for k = 1 … `N_TICKS-1`.
- No `tick` is generated on the expiry edge; `t300ms` is generated instead.
- `actCuenta` is synchronous to `Clk` and needs no synchronizer here; it comes from the debouncer.
- Minimum gap between two pulses: `actCuenta` must be low for ≥ 1 sampled edge, then high again, then a full interval.

## Structure
- Shared header `temporizador_defs.vh`:
  - State encodings `ST_IDLE`=2'd0, `ST_COUNT`=2'd1, `ST_DONE`=2'd2.
  - Default `TICK_CYCLES`/`N_TICKS` constants.
  - Simulation values `SIM_TICK_CYCLES`=4, `SIM_N_TICKS`=3.
- Sub-module `divisor_tick`:
  - Inputs: clear, enable.
  - Output: `tick` when the count reaches `TICK_CYCLES-1`.
  - Instantiated once.
- The FSM and `ticks` counter live in the top module.

## Test plan
All scenarios use `TICK_CYCLES`=4, `N_TICKS`=3, 20 ns clock period.
- Reset, then idle: assert `Reset` for 2 cycles with `actCuenta`=0 → `t300ms`, `contando` and `tick` stay 0 for 30 cycles.
- Nominal interval: raise `actCuenta` at E0 and hold it → `contando`=1 from E0; `tick` pulses after E0+4 and E0+8; a single `t300ms` pulse after E0+12; `contando`=0 after E0+12.
- Hold in `DONE`: keep `actCuenta`=1 for 20 more cycles → no second `t300ms`. Drop `actCuenta` for 1 edge, raise it again → next pulse exactly 12 edges after re-sampling.
- Abort: drop `actCuenta` after E0+7 → `contando`=0 next edge, no `t300ms`. Re-request → full 12-cycle interval.
- Expiry collision: `actCuenta`=0 sampled at E0+12 → no `t300ms`, state `IDLE`.
- Async reset mid-count: pulse `Reset` between edges at E0+6 → outputs 0 immediately, without waiting for a clock edge. With `actCuenta` still high after release, `t300ms` appears 12 edges after the first post-reset edge.

Source files
------------

// File: rtl/temporizador_antirrebote_pkg.sv
// rtl/temporizador_antirrebote_pkg.sv - shared encodings and constants for the debounce timer
//
// Purpose: FSM state encoding, board default interval constants and the
// reduced constants used for simulation.
package temporizador_antirrebote_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } estado_t;

  // 1 ms base tick at 100 MHz, 300 ticks per interval.
  localparam int TICK_CYCLES_DEF = 100000;
  localparam int N_TICKS_DEF     = 300;

  // Short interval for simulation: 4 cycles per tick, 3 ticks.
  localparam int SIM_TICK_CYCLES = 4;
  localparam int SIM_N_TICKS     = 3;

endpackage

// File: rtl/temporizador_antirrebote_divisor_tick.sv
// rtl/temporizador_antirrebote_divisor_tick.sv - prescaler producing the base-tick strobe
//
// Purpose: counts enabled clock cycles modulo TICK_CYCLES.
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   clear  - synchronous clear of the prescaler (has priority over enable)
//   enable - advance the prescaler this cycle
//   wrap   - combinational: count is at TICK_CYCLES-1 and enabled, so this
//            edge completes a base tick
module divisor_tick
  import temporizador_antirrebote_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic wrap
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_CYCLES - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  assign wrap = enable && (pre_q == PRE_MAX);

  always_comb begin
    pre_d = pre_q;
    if (clear) begin
      pre_d = '0;
    end else if (enable) begin
      pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/temporizador_antirrebote.sv
// rtl/temporizador_antirrebote.sv - debounce interval timer (request level in, single-cycle expiry pulse out)
//
// Purpose: while actCuenta is held high, time TICK_CYCLES*N_TICKS clock
// cycles and emit one t300ms pulse; stay quiet until the request drops.
// Ports:
//   Clk       - system clock, rising edge
//   Reset     - asynchronous active-high reset
//   actCuenta - count request level from the debouncer
//   t300ms    - registered one-cycle interval-expired pulse
//   contando  - registered, high while an interval is being timed
//   tick      - registered one-cycle base-tick strobe (debug)
module temporizador_antirrebote
  import temporizador_antirrebote_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEF,
  parameter int N_TICKS     = N_TICKS_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic actCuenta,
  output logic t300ms,
  output logic contando,
  output logic tick
);

  localparam int TW = $clog2(N_TICKS + 1);
  localparam logic [TW-1:0] TICKS_MAX = TW'(N_TICKS - 1);

  estado_t       state_q, state_d;
  logic [TW-1:0] ticks_q, ticks_d;
  logic          t300ms_q, t300ms_d;
  logic          contando_q, contando_d;
  logic          tick_q, tick_d;

  logic pre_clear;
  logic pre_enable;
  logic pre_wrap;

  // The prescaler only runs in COUNT with the request still high; any other
  // edge (idle, done, abort) leaves it at zero so a new request starts fresh.
  assign pre_enable = (state_q == ST_COUNT) && actCuenta;
  assign pre_clear  = !pre_enable;

  divisor_tick #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_divisor_tick (
    .clk   (Clk),
    .rst   (Reset),
    .clear (pre_clear),
    .enable(pre_enable),
    .wrap  (pre_wrap)
  );

  always_comb begin
    state_d    = state_q;
    ticks_d    = ticks_q;
    t300ms_d   = 1'b0;
    contando_d = 1'b0;
    tick_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ticks_d = '0;
        if (actCuenta) begin
          state_d    = ST_COUNT;
          contando_d = 1'b1;
        end
      end
      ST_COUNT: begin
        if (!actCuenta) begin
          // Abort, also when it coincides with expiry: no pulse.
          state_d = ST_IDLE;
          ticks_d = '0;
        end else if (pre_wrap) begin
          if (ticks_q == TICKS_MAX) begin
            // Final tick is replaced by the expiry pulse.
            state_d  = ST_DONE;
            ticks_d  = '0;
            t300ms_d = 1'b1;
          end else begin
            ticks_d    = ticks_q + TW'(1);
            tick_d     = 1'b1;
            contando_d = 1'b1;
          end
        end else begin
          contando_d = 1'b1;
        end
      end
      ST_DONE: begin
        ticks_d = '0;
        if (!actCuenta) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ticks_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      ticks_q    <= '0;
      t300ms_q   <= 1'b0;
      contando_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ticks_q    <= ticks_d;
      t300ms_q   <= t300ms_d;
      contando_q <= contando_d;
      tick_q     <= tick_d;
    end
  end

  assign t300ms   = t300ms_q;
  assign contando = contando_q;
  assign tick     = tick_q;

endmodule
